pipe_hazard_ctrl: RTL and testbench

Central pipeline controller for the 5-stage ARM-subset core. Sequences every inter-stage register (regFD, regDE, regEM, regMW) with per-stage stall and flush controls, and drives the E-stage operand forwarding muxes. Holds the pipeline while the data memory completes a multi-cycle access, and times out a hung access. Sits beside the datapath. It is purely a control source and carries no data.

---
 rtl/core_pkg.sv | 34 +++
 rtl/hz_mem_wait.sv | 54 +++++
 rtl/pipe_hazard_ctrl.sv | 110 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// Forwarding behaviour is selected by the HAZ_FORWARD_EN macro at the top level.
package core_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_t;

    localparam logic [3:0] REG_PC = 4'd15;

    // The PC reads its own live value, so r15 never takes part in a dependency.
    function automatic logic regMatch(input logic [3:0] src, input logic [3:0] dst,
                                      input logic we);
        return we && (src == dst) && (src != REG_PC);
    endfunction

    function automatic fwd_sel_t fwdSel(input logic [3:0] src,
                                        input logic [3:0] wa3M, input logic weM,
                                        input logic [3:0] wa3W, input logic weW);
        if (regMatch(src, wa3M, weM))
            return FWD_M;
        if (regMatch(src, wa3W, weW))
            return FWD_W;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hz_mem_wait.sv
// Data-memory wait tracker: holds the pipe while an M-stage access is pending
// and releases it with a timeout flag once MEM_TIMEOUT cycles have elapsed.
module hz_mem_wait
    import core_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic CLK,
    input  logic reset,
    input  logic MemReqM,
    input  logic MemReadyM,
    output logic memStall,
    output logic timeoutHit
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT);

    hz_state_t         state;
    logic [WCNT_W-1:0] waitCnt;

    // waitCnt holds the number of cycles this access has already spent waiting,
    // so the last permitted cycle is cycle MEM_TIMEOUT of the access.
    assign timeoutHit = (state == MEM_WAIT) && (waitCnt == WCNT_W'(MEM_TIMEOUT - 1))
                        && MemReqM && !MemReadyM;
    assign memStall   = MemReqM && !MemReadyM && !timeoutHit;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state   <= RUN;
            waitCnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (memStall) begin
                        state   <= MEM_WAIT;
                        waitCnt <= WCNT_W'(1);
                    end else begin
                        waitCnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (memStall) begin
                        waitCnt <= waitCnt + 1'b1;
                    end else begin
                        state   <= RUN;
                        waitCnt <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush/forward controller for the 5-stage core.
// Define HAZ_FORWARD_EN for E-stage forwarding; otherwise RAW hazards interlock.
module pipe_hazard_ctrl
    import core_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [3:0]       RA1D,
    input  logic [3:0]       RA2D,
    input  logic [3:0]       RA1E,
    input  logic [3:0]       RA2E,
    input  logic [3:0]       WA3E,
    input  logic [3:0]       WA3M,
    input  logic [3:0]       WA3W,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             PCSrcD,
    input  logic             PCSrcE,
    input  logic             PCSrcM,
    input  logic             PCSrcW,
    input  logic             BranchTakenE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             MemErrM,
    output logic [CNT_W-1:0] StallCount
);

    logic memStall;
    logic timeoutHit;
    logic dHold;
    logic pcWrPend;

    hz_mem_wait #(.MEM_TIMEOUT(MEM_TIMEOUT)) uMemWait (
        .CLK        (CLK),
        .reset      (reset),
        .MemReqM    (MemReqM),
        .MemReadyM  (MemReadyM),
        .memStall   (memStall),
        .timeoutHit (timeoutHit)
    );

`ifdef HAZ_FORWARD_EN
    logic ldrStall;

    assign ldrStall  = MemtoRegE && (regMatch(RA1D, WA3E, RegWriteE) ||
                                     regMatch(RA2D, WA3E, RegWriteE));
    assign dHold     = ldrStall;
    assign ForwardAE = fwdSel(RA1E, WA3M, RegWriteM, WA3W, RegWriteW);
    assign ForwardBE = fwdSel(RA2E, WA3M, RegWriteM, WA3W, RegWriteW);
`else
    // Without bypass paths any producer still in E or M must drain first; W is
    // covered by the write-first register file.
    assign dHold     = regMatch(RA1D, WA3E, RegWriteE) || regMatch(RA2D, WA3E, RegWriteE) ||
                       regMatch(RA1D, WA3M, RegWriteM) || regMatch(RA2D, WA3M, RegWriteM);
    assign ForwardAE = FWD_RF;
    assign ForwardBE = FWD_RF;

    logic unusedFwdInputs;
    assign unusedFwdInputs = ^{RA1E, RA2E, WA3W, RegWriteW, MemtoRegE};
`endif

    assign pcWrPend = PCSrcD || PCSrcE || PCSrcM;
    assign MemErrM  = timeoutHit;

    // NOTE: every output gets a default first so no path through this block infers a latch.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (memStall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else begin
            StallF = dHold || pcWrPend;
            // A taken branch discards the held D instruction instead of keeping it.
            StallD = dHold && !BranchTakenE;
            FlushD = pcWrPend || PCSrcW || BranchTakenE;
            FlushE = dHold || BranchTakenE;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset)
            StallCount <= '0;
        else if (StallF && (StallCount != '1))
            StallCount <= StallCount + 1'b1;
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed cases then randomized traffic
// against a cycle-level behavioural model; follows HAZ_FORWARD_EN like the DUT.
module tb_pipe_hazard_ctrl;

    localparam int MEM_TO  = 4;
    localparam int CNT_W   = 5;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             CLK = 1'b0;
    logic             reset;
    logic [3:0]       RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic             RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
    logic             PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
    logic             MemReqM, MemReadyM;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             StallF, StallD, StallE, StallM;
    logic             FlushD, FlushE, FlushW, MemErrM;
    logic [CNT_W-1:0] StallCount;

    int nChecks = 0;
    int nPass   = 0;
    int waited  = 0;   // cycles the current access has already stalled
    int cntRef  = 0;   // reference stall-cycle counter

    always #5 CLK = ~CLK;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TO), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .reset(reset),
        .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE),
        .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
        .BranchTakenE(BranchTakenE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .MemErrM(MemErrM), .StallCount(StallCount)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp)
            nPass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic bit dep(input logic [3:0] src, input logic [3:0] dst, input logic we);
        return we && (src == dst) && (src != 4'd15);
    endfunction

    // Expected {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,MemErrM} and forward selects.
    function automatic void predict(output logic [7:0] ctl, output logic [1:0] fa,
                                    output logic [1:0] fb);
        bit pending, timeout, hold, pcw, br;
        pending = MemReqM && !MemReadyM;
        timeout = pending && (waited == MEM_TO - 1);
        pcw     = PCSrcD || PCSrcE || PCSrcM;
        br      = BranchTakenE;
`ifdef HAZ_FORWARD_EN
        hold = MemtoRegE && (dep(RA1D, WA3E, RegWriteE) || dep(RA2D, WA3E, RegWriteE));
        fa   = dep(RA1E, WA3M, RegWriteM) ? 2'd2 : dep(RA1E, WA3W, RegWriteW) ? 2'd1 : 2'd0;
        fb   = dep(RA2E, WA3M, RegWriteM) ? 2'd2 : dep(RA2E, WA3W, RegWriteW) ? 2'd1 : 2'd0;
`else
        hold = dep(RA1D, WA3E, RegWriteE) || dep(RA2D, WA3E, RegWriteE) ||
               dep(RA1D, WA3M, RegWriteM) || dep(RA2D, WA3M, RegWriteM);
        fa   = 2'd0;
        fb   = 2'd0;
`endif
        if (pending && !timeout)
            ctl = 8'b1111_0010;
        else
            ctl = {hold || pcw, hold && !br, 2'b00, pcw || PCSrcW || br, hold || br, 1'b0, timeout};
    endfunction

    // Check one cycle mid-period, then advance the model across the clock edge.
    task automatic stepCheck(input string tag);
        logic [7:0] ctl;
        logic [1:0] fa, fb;
        #4;
        predict(ctl, fa, fb);
        check({tag, ".ctl"}, {24'd0, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErrM}, {24'd0, ctl});
        check({tag, ".fwdA"}, {30'd0, ForwardAE}, {30'd0, fa});
        check({tag, ".fwdB"}, {30'd0, ForwardBE}, {30'd0, fb});
        check({tag, ".cnt"}, {{(32-CNT_W){1'b0}}, StallCount}, cntRef);
        @(posedge CLK);
        if (reset) begin
            waited = 0;
            cntRef = 0;
        end else begin
            waited = (ctl[7:4] == 4'hF) ? waited + 1 : 0;
            if (ctl[7] && cntRef != CNT_MAX)
                cntRef++;
        end
        #1;
    endtask

    task automatic clearIns();
        {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W} = '0;
        {RegWriteE, RegWriteM, RegWriteW, MemtoRegE} = '0;
        {PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MemReqM, MemReadyM} = '0;
    endtask

    task automatic loadR2InE();
        MemtoRegE = 1'b1;
        WA3E      = 4'd2;
        RegWriteE = 1'b1;
        RA2D      = 4'd2;
    endtask

    function automatic logic [3:0] pickReg();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 4'd15 : 4'(r);
    endfunction

    initial begin
        bit reqHeld;
        clearIns();
        reset = 1'b1;
        @(posedge CLK);
        #1;
        stepCheck("reset");
        check("resetOutsZero", {20'd0, ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
                                FlushD, FlushE, FlushW, MemErrM, StallCount}, 32'd0);
        reset = 1'b0;

        // Forward priority: M beats W; r15 never forwards.
        RA1E = 4'd3; WA3M = 4'd3; RegWriteM = 1'b1; WA3W = 4'd3; RegWriteW = 1'b1;
`ifdef HAZ_FORWARD_EN
        #4 check("fwdMPrio", {30'd0, ForwardAE}, 32'd2);
        #0;
`endif
        stepCheck("fwdM");
        RA1E = 4'd15;
        stepCheck("fwdPc");
        clearIns();

        // Load-use: one bubble.
        loadR2InE();
        stepCheck("ldrUse");
        clearIns();
        stepCheck("ldrDone");

        // Ready on the 4th cycle of M: three held cycles.
        MemReqM = 1'b1;
        repeat (3) stepCheck("memWait");
        MemReadyM = 1'b1;
        stepCheck("memReady");
        clearIns();
        stepCheck("memIdle");

        // Access that never completes: MEM_TO-1 held cycles, then the error pulse.
        MemReqM = 1'b1;
        repeat (MEM_TO - 1) stepCheck("toWait");
        #4 check("toErr", {31'd0, MemErrM}, 32'd1);
        check("toRelease", {31'd0, StallM}, 32'd0);
        #0;
        stepCheck("toHit");
        clearIns();
        stepCheck("toIdle");

        // Taken branch alongside a load-use hazard, then the same under a memory stall.
        loadR2InE();
        BranchTakenE = 1'b1;
        #4 check("brLdr", {29'd0, FlushD, FlushE, StallD}, 32'b110);
        #0;
        stepCheck("brLdr");
        MemReqM = 1'b1;
        stepCheck("brLdrMem");
        clearIns();
        stepCheck("brIdle");

        // RAW against M: interlock without forwarding, bypass with it.
        RA1D = 4'd4; WA3M = 4'd4; RegWriteM = 1'b1;
        stepCheck("rawM");
        clearIns();

        // Saturation of the stall counter.
        PCSrcD = 1'b1;
        repeat (CNT_MAX + 4) stepCheck("sat");
        clearIns();

        // Reset in the middle of an access abandons it.
        MemReqM = 1'b1;
        repeat (2) stepCheck("rstMid");
        reset = 1'b1;
        stepCheck("rstMidReset");
        reset = 1'b0;
        repeat (MEM_TO) stepCheck("rstMidAfter");
        clearIns();

        // Randomized traffic.
        reqHeld = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            RA1D = pickReg(); RA2D = pickReg(); RA1E = pickReg(); RA2E = pickReg();
            WA3E = pickReg(); WA3M = pickReg(); WA3W = pickReg();
            RegWriteE    = 1'($urandom_range(0, 1));
            RegWriteM    = 1'($urandom_range(0, 1));
            RegWriteW    = 1'($urandom_range(0, 1));
            MemtoRegE    = 1'($urandom_range(0, 2) == 0);
            PCSrcD       = 1'($urandom_range(0, 9) == 0);
            PCSrcE       = 1'($urandom_range(0, 9) == 0);
            PCSrcM       = 1'($urandom_range(0, 9) == 0);
            PCSrcW       = 1'($urandom_range(0, 9) == 0);
            BranchTakenE = 1'($urandom_range(0, 7) == 0);
            if (!reqHeld)
                reqHeld = ($urandom_range(0, 3) == 0);
            MemReqM   = reqHeld;
            MemReadyM = reqHeld && ($urandom_range(0, 4) == 0);
            reset     = ($urandom_range(0, 199) == 0);
            stepCheck("rand");
            if (MemReadyM || reset || $urandom_range(0, 7) == 0)
                reqHeld = 1'b0;
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
